store_write_buffer: RTL

//   Downstream of the two-beat store splitter: queues store beats (incl. both halves
//   of split stores, addr and addr+8) leaving the MEM stage and drains them in order
//   to the data-memory write port over a req/ack handshake. Back-pressures the pipe

---
 rtl/store_write_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: queues store beats leaving MEM and drains them in order to the
// data-memory write port over a req/ack handshake. Flags loads that hit a pending
// store at doubleword granularity.
module store_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned MASK_W = DATA_W / 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [MASK_W-1:0] st_mask_i,
    output logic              st_ready_o,
    output logic              stall_store_o,
    input  logic              ld_check_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_hazard_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [MASK_W-1:0] mask_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q, head_addr;
    logic [DATA_W-1:0] data_q, head_data;
    logic [MASK_W-1:0] mask_q, head_mask;
    logic              push, pop, ld_hit;

    // Byte offset within a doubleword is irrelevant to the hazard compare.
    logic unused_ld_low;
    assign unused_ld_low = ^ld_addr_i[2:0];

    assign st_ready_o    = (count_q != CNT_W'(DEPTH));
    assign stall_store_o = st_valid_i && !st_ready_o;
    assign push          = st_valid_i && st_ready_o;
    assign pop           = req_q && mem_ack_i;

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign mem_wmask_o = mask_q;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);

    // Next pointers/count and the entry that will sit at the head after this edge.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        // When the new head is the beat being written this edge, take it from the inputs
        // so the request can go out the very next cycle.
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_addr = st_addr_i;
            head_data = st_data_i;
            head_mask = st_mask_i;
        end else begin
            head_addr = addr_mem[rd_ptr_d];
            head_data = data_mem[rd_ptr_d];
            head_mask = mask_mem[rd_ptr_d];
        end
    end

    // Entry storage; contents need no reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= st_addr_i;
            data_mem[wr_ptr_q] <= st_data_i;
            mask_mem[wr_ptr_q] <= st_mask_i;
        end
    end

    // Pointer/count bookkeeping and the drain FSM with registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            unique case (state_q)
                StIdle: begin
                    if (count_d != '0) begin
                        state_q <= StIssue;
                        req_q   <= 1'b1;
                        addr_q  <= head_addr;
                        data_q  <= head_data;
                        mask_q  <= head_mask;
                    end
                end
                StIssue: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            addr_q <= head_addr;
                            data_q <= head_data;
                            mask_q <= head_mask;
                        end else begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            mask_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Load hazard: any occupied slot in the same doubleword; same-cycle push not seen.
    always_comb begin
        ld_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) &&
                (addr_mem[i][ADDR_W-1:3] == ld_addr_i[ADDR_W-1:3])) begin
                ld_hit = 1'b1;
            end
        end
        ld_hazard_o = ld_check_i && ld_hit;
    end

endmodule
